write_burst_arbiter: RTL and testbench

WRITE_BURST_ARBITER -- requirements
Module: write_burst_arbiter

---
 rtl/snappy_io_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/write_burst_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_write_burst_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snappy_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snappy_io_pkg
//  Description : Shared types and constants for the write-burst path: FSM
//                state encoding, 64 B beat / 4 KB boundary geometry and the
//                remaining-beat counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package snappy_io_pkg;

    localparam int c_BEAT_BYTES     = 64;
    localparam int c_BOUNDARY_BYTES = 4096;
    localparam int c_BEATS_PER_4K   = c_BOUNDARY_BYTES / c_BEAT_BYTES;
    localparam int c_BEAT_CNT_W     = 27;   // ceil((2^32-1)/64) = 2^26 needs 27 bits
    localparam int c_BURST_W        = 7;    // one burst carries 1..64 beats

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_NEXT = 3'd4
    } wba_state_t;

    // Byte length to 64 B beat count, rounded up; a 33-bit sum avoids overflow
    // for lengths near 2^32.
    function automatic logic [c_BEAT_CNT_W-1:0] len_to_beats(input logic [31:0] len);
        logic [32:0] sum;
        sum = {1'b0, len} + 33'(c_BEAT_BYTES - 1);
        return sum[32:6];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin selector. Searches the request
//                vector starting at last_grant+1 (mod NUM_REQ).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int NUM_REQ_LOG = 2
) (
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ_LOG-1:0] i_last_grant,
    output logic [NUM_REQ_LOG-1:0] o_grant,
    output logic                   o_any
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int w_idx;
        w_idx   = 0;
        o_grant = '0;
        o_any   = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = (int'(i_last_grant) + k) % NUM_REQ;
            if (i_req[w_idx]) begin
                o_grant = NUM_REQ_LOG'(w_idx);
                o_any   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/write_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : write_burst_arbiter
//  Description : Arbitrates decompressor output jobs onto one AXI-style write
//                channel, splitting each job into bursts that never cross a
//                4 KB boundary. Data is a zero-latency pass-through.
//                Optional macro WBA_BRESP_WAIT_EN adds bvalid/bready and holds
//                job_done until every issued burst has been acknowledged.
//  Revision    : 1.0 - initial release
// ============================================================================
module write_burst_arbiter
    import snappy_io_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int NUM_REQ_LOG = 2,
    parameter int DATA_W      = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*64-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]   req_len,
    output logic [NUM_REQ-1:0]      req_ack,
    input  logic [NUM_REQ*DATA_W-1:0] src_data,
    input  logic [NUM_REQ-1:0]      src_valid,
    output logic [NUM_REQ-1:0]      src_ready,
    output logic [NUM_REQ-1:0]      job_done,
    output logic                    wr_req,
    input  logic                    wr_req_ack,
    output logic [63:0]             wr_address,
    output logic [7:0]              wr_len,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic                    wr_data_last,
    output logic                    busy
`ifdef WBA_BRESP_WAIT_EN
    ,
    input  logic                    bvalid,
    output logic                    bready
`endif
);

    wba_state_t                 r_state;
    logic [NUM_REQ_LOG-1:0]     r_grant;
    logic [NUM_REQ_LOG-1:0]     r_last_grant;
    logic [63:0]                r_addr;
    logic [c_BEAT_CNT_W-1:0]    r_remaining;
    logic [c_BURST_W-1:0]       r_burst;
    logic [c_BURST_W-1:0]       r_beat_cnt;
    logic                       r_wr_req;
    logic [63:0]                r_wr_addr;
    logic [7:0]                 r_wr_len;
    logic [NUM_REQ-1:0]         r_req_ack;
    logic [NUM_REQ-1:0]         r_job_done;

    logic [NUM_REQ_LOG-1:0]     w_arb_grant;
    logic                       w_arb_any;
    logic [63:0]                w_sel_addr;
    logic [31:0]                w_sel_len;
    logic [c_BEAT_CNT_W-1:0]    w_len_beats;
    logic [c_BURST_W-1:0]       w_room;
    logic [c_BURST_W-1:0]       w_burst;
    logic [c_BEAT_CNT_W-1:0]    w_rem_next;
    logic                       w_in_data;
    logic                       w_beat_fire;
    logic                       w_bresp_ok;
    logic [NUM_REQ-1:0]         w_src_ready;

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .NUM_REQ_LOG (NUM_REQ_LOG)
    ) u_rr_arbiter (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_any        (w_arb_any)
    );

    assign w_sel_addr  = req_addr[int'(w_arb_grant)*64 +: 64];
    assign w_sel_len   = req_len[int'(w_arb_grant)*32 +: 32];
    assign w_len_beats = len_to_beats(w_sel_len);

    // Beats left before the next 4 KB boundary (1..64), then clipped to the job.
    assign w_room      = c_BURST_W'(c_BEATS_PER_4K) - {1'b0, r_addr[11:6]};
    assign w_burst     = (r_remaining < c_BEAT_CNT_W'(w_room)) ? r_remaining[c_BURST_W-1:0] : w_room;
    assign w_rem_next  = r_remaining - c_BEAT_CNT_W'(r_burst);

    assign w_in_data   = (r_state == ST_DATA);
    assign w_beat_fire = w_in_data && src_valid[r_grant] && wr_ready;

`ifdef WBA_BRESP_WAIT_EN
    logic [c_BEAT_CNT_W-1:0] r_bursts_issued;
    logic [c_BEAT_CNT_W-1:0] r_bresp_seen;

    // Count accepted bursts and write responses for the current job.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bursts_issued <= '0;
            r_bresp_seen    <= '0;
        end else if (r_state == ST_ARB) begin
            r_bursts_issued <= '0;
            r_bresp_seen    <= '0;
        end else begin
            if (r_state == ST_ADDR && r_wr_req && wr_req_ack)
                r_bursts_issued <= r_bursts_issued + 1'b1;
            if (bvalid)
                r_bresp_seen <= r_bresp_seen + 1'b1;
        end
    end

    assign bready     = 1'b1;
    assign w_bresp_ok = (r_bursts_issued == r_bresp_seen);
`else
    assign w_bresp_ok = 1'b1;
`endif

    // Job sequencing: arbitrate, split into 4 KB-safe bursts, stream beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= NUM_REQ_LOG'(NUM_REQ - 1);
            r_addr       <= '0;
            r_remaining  <= '0;
            r_burst      <= '0;
            r_beat_cnt   <= '0;
            r_wr_req     <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_len     <= '0;
            r_req_ack    <= '0;
            r_job_done   <= '0;
        end else begin
            r_req_ack  <= '0;
            r_job_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid)
                        r_state <= ST_ARB;
                end
                ST_ARB: begin
                    if (w_arb_any) begin
                        r_grant     <= w_arb_grant;
                        r_addr      <= w_sel_addr;
                        r_remaining <= w_len_beats;
                        r_burst     <= '0;
                        r_req_ack   <= NUM_REQ'(1) << w_arb_grant;
                        // A zero-length job goes straight to completion.
                        r_state     <= (w_len_beats == '0) ? ST_NEXT : ST_ADDR;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    // First cycle loads the burst; address/len then stay frozen
                    // until the request is accepted.
                    if (!r_wr_req) begin
                        r_wr_req   <= 1'b1;
                        r_wr_addr  <= r_addr;
                        r_wr_len   <= 8'(w_burst) - 8'd1;
                        r_burst    <= w_burst;
                        r_beat_cnt <= w_burst;
                    end else if (wr_req_ack) begin
                        r_wr_req <= 1'b0;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_beat_fire) begin
                        r_beat_cnt <= r_beat_cnt - 1'b1;
                        if (r_beat_cnt == c_BURST_W'(1))
                            r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // Clearing r_burst makes repeated NEXT cycles (waiting on
                    // write responses) leave address and count untouched.
                    r_addr      <= r_addr + 64'({r_burst, 6'b0});
                    r_remaining <= w_rem_next;
                    r_burst     <= '0;
                    if (w_rem_next != '0) begin
                        r_state <= ST_ADDR;
                    end else if (w_bresp_ok) begin
                        r_job_done   <= NUM_REQ'(1) << r_grant;
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Only the granted source sees the sink's ready during a data phase.
    always_comb begin
        w_src_ready = '0;
        if (!rst && w_in_data)
            w_src_ready[r_grant] = wr_ready;
    end

    assign src_ready    = w_src_ready;
    assign wr_data      = src_data[int'(r_grant)*DATA_W +: DATA_W];
    assign wr_valid     = !rst && w_in_data && src_valid[r_grant];
    assign wr_data_last = !rst && w_in_data && (r_beat_cnt == c_BURST_W'(1));
    assign wr_req       = !rst && r_wr_req;
    assign wr_address   = r_wr_addr;
    assign wr_len       = r_wr_len;
    assign req_ack      = rst ? '0 : r_req_ack;
    assign job_done     = rst ? '0 : r_job_done;
    assign busy         = !rst && (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_write_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_write_burst_arbiter
//  Description : Randomized self-checking bench for write_burst_arbiter.
//                Jobs are issued in rounds; a reference model predicts grant
//                order, burst split, beat data and completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_write_burst_arbiter;

    localparam int N  = 3;
    localparam int DW = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*64-1:0]   req_addr;
    logic [N*32-1:0]   req_len;
    logic [N-1:0]      req_ack;
    logic [N*DW-1:0]   src_data;
    logic [N-1:0]      src_valid;
    logic [N-1:0]      src_ready;
    logic [N-1:0]      job_done;
    logic              wr_req;
    logic              wr_req_ack;
    logic [63:0]       wr_address;
    logic [7:0]        wr_len;
    logic [DW-1:0]     wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_data_last;
    logic              busy;
`ifdef WBA_BRESP_WAIT_EN
    logic              bvalid;
    logic              bready;
    int                bpend;
`endif

    always #5 clk = ~clk;

    write_burst_arbiter #(.NUM_REQ(N), .NUM_REQ_LOG(2), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ack(req_ack),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready), .job_done(job_done),
        .wr_req(wr_req), .wr_req_ack(wr_req_ack), .wr_address(wr_address), .wr_len(wr_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data_last(wr_data_last), .busy(busy)
`ifdef WBA_BRESP_WAIT_EN
        , .bvalid(bvalid), .bready(bready)
`endif
    );

    // ---------------- bookkeeping / reference model ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] job_addr [N];
    logic [31:0] job_len  [N];
    int          exp_order[$];
    longint      bq_addr[$];
    int          bq_beats[$];
    int          last_grant_m = N - 1;
    int          cur_grant = -1;
    logic [31:0] cur_len;
    int          burst_left = 0;
    int          job_beats = 0;
    int          ack_cyc = 0;
    int          dones = 0;
    int          src_cnt[N];
    int          exp_cnt[N];
    bit          ack_flag[N];
    bit          prev_wr_req = 1'b0;
    logic [71:0] prev_req_fields;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int r, input int k);
        logic [DW-1:0] v;
        for (int j = 0; j < DW/32; j++)
            v[j*32 +: 32] = (32'(r) * 32'h9E3779B9) ^ (32'(k) * 32'h85EBCA6B) ^ 32'(j) ^ 32'h5A5A0000;
        return v;
    endfunction

    // Expected burst list: split at 4 KB boundaries, 64 B beats.
    task automatic load_bursts(input int g);
        longint a, beats, b;
        a     = longint'(job_addr[g]);
        beats = (longint'(job_len[g]) + 63) / 64;
        while (beats > 0) begin
            b = 64 - ((a / 64) % 64);
            if (b > beats) b = beats;
            bq_addr.push_back(a);
            bq_beats.push_back(int'(b));
            a     = a + b * 64;
            beats = beats - b;
        end
    endtask

    // ---------------- monitor (negedge sampling) ----------------
    always @(negedge clk) begin
        logic [N-1:0] mask;
        cyc++;
        if (rst) begin
            check_eq("rst_outputs", DW'({busy, wr_req, wr_valid, wr_data_last, req_ack, src_ready, job_done}), '0);
        end else begin
            mask = (cur_grant >= 0) ? N'(1) << cur_grant : '0;
            if ((src_ready & ~mask) != '0)
                check_eq("src_ready_idx", DW'(src_ready), DW'(src_ready & mask));

            if (req_ack != '0) begin
                if (exp_order.size() == 0) begin
                    check_eq("req_ack_unexp", DW'(req_ack), '0);
                end else begin
                    check_eq("req_ack", DW'(req_ack), DW'(N'(1) << exp_order[0]));
                    cur_grant = exp_order.pop_front();
                    cur_len   = job_len[cur_grant];
                    ack_cyc   = cyc;
                    job_beats = 0;
                    load_bursts(cur_grant);
                end
                for (int i = 0; i < N; i++) if (req_ack[i]) ack_flag[i] = 1'b1;
            end

            if (wr_req && prev_wr_req)
                check_eq("wr_req_hold", DW'({wr_address, wr_len}), DW'(prev_req_fields));

            if (wr_req && wr_req_ack) begin
                if (bq_addr.size() == 0) begin
                    check_eq("burst_unexp", DW'(1), '0);
                end else begin
                    check_eq("wr_address", DW'(wr_address), DW'(bq_addr[0]));
                    check_eq("wr_len", DW'(wr_len), DW'(bq_beats[0] - 1));
                    burst_left = bq_beats[0];
                    void'(bq_addr.pop_front());
                    void'(bq_beats.pop_front());
                end
            end else if (wr_valid && burst_left == 0) begin
                check_eq("beat_before_ack", DW'(wr_valid), '0);
            end

            if (wr_valid && wr_ready && burst_left > 0 && cur_grant >= 0) begin
                check_eq("wr_data", wr_data, pat(cur_grant, exp_cnt[cur_grant]));
                check_eq("wr_last", DW'(wr_data_last), DW'(burst_left == 1));
                exp_cnt[cur_grant]++;
                burst_left--;
                job_beats++;
            end

            for (int i = 0; i < N; i++)
                if (src_valid[i] && src_ready[i]) src_cnt[i]++;

`ifdef WBA_BRESP_WAIT_EN
            if (wr_valid && wr_ready && wr_data_last) bpend++;
            if (bvalid && bready) bpend--;
`endif

            if (job_done != '0) begin
                check_eq("job_done", DW'(job_done), DW'((cur_grant >= 0) ? N'(1) << cur_grant : '0));
                check_eq("job_left", DW'(bq_beats.size() + burst_left), '0);
                if (cur_len == 32'd0)
                    check_eq("zero_done_lat", DW'(cyc - ack_cyc), DW'(1));
                if (cur_grant >= 0) last_grant_m = cur_grant;
                cur_grant = -1;
                dones++;
            end

            prev_wr_req     = wr_req && !wr_req_ack;
            prev_req_fields = {wr_address, wr_len};
        end
    end

    // ---------------- input driver (1 unit after posedge) ----------------
    initial begin
        src_valid  = '0;
        src_data   = '0;
        wr_ready   = 1'b0;
        wr_req_ack = 1'b0;
`ifdef WBA_BRESP_WAIT_EN
        bvalid = 1'b0;
        bpend  = 0;
`endif
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (ack_flag[i]) begin
                    req_valid[i] = 1'b0;
                    ack_flag[i]  = 1'b0;
                end
                src_valid[i]           = ($urandom % 4) != 0;
                src_data[i*DW +: DW]   = pat(i, src_cnt[i]);
            end
            wr_ready   = ($urandom % 4) != 0;
            wr_req_ack = ($urandom % 3) == 0;
`ifdef WBA_BRESP_WAIT_EN
            bvalid = (bpend > 0) && ($urandom % 2 == 0);
`endif
        end
    end

    // ---------------- round helpers ----------------
    task automatic start_round(input logic [N-1:0] set);
        exp_order.delete();
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last_grant_m + k) % N;
            if (set[idx]) exp_order.push_back(idx);
        end
        dones = 0;
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            req_addr[i*64 +: 64] = job_addr[i];
            req_len[i*32 +: 32]  = job_len[i];
        end
        req_valid = set;
    endtask

    task automatic wait_round(input int target);
        int t;
        t = 0;
        while (dones < target && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (dones < target) check_eq("round_timeout", DW'(dones), DW'(target));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("idle_after_round", DW'({busy, wr_req, wr_valid}), '0);
    endtask

    task automatic run_round(input logic [N-1:0] set);
        start_round(set);
        wait_round($countones(set));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [N-1:0] set;
        int           t;
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        for (int i = 0; i < N; i++) begin
            src_cnt[i] = 0; exp_cnt[i] = 0; ack_flag[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_state", DW'({busy, wr_req, wr_valid, wr_data_last, req_ack, src_ready, job_done}), '0);

        // All three from reset: full 4 KB page, boundary split, zero length.
        job_addr[0] = 64'h1000; job_len[0] = 32'd4096;
        job_addr[1] = 64'h1F80; job_len[1] = 32'd200;
        job_addr[2] = 64'h3000; job_len[2] = 32'd0;
        run_round(3'b111);
        job_addr[0] = 64'h40;   job_len[0] = 32'd100;
        run_round(3'b001);

        for (int r = 0; r < 30; r++) begin
            set = N'($urandom_range(1, 7));
            for (int i = 0; i < N; i++) begin
                int slot, sel;
                slot = (($urandom % 3) == 0) ? int'($urandom_range(56, 63)) : int'($urandom_range(0, 63));
                job_addr[i] = (64'($urandom_range(0, 1023)) << 12) | (64'(slot) << 6);
                sel = $urandom % 8;
                job_len[i] = (sel == 0) ? 32'd0 :
                             (sel == 1) ? 32'($urandom_range(1, 64)) : 32'($urandom_range(1, 1500));
            end
            run_round(set);
        end

        // Reset in the middle of a data burst.
        job_addr[1] = 64'h0; job_len[1] = 32'd4096;
        start_round(3'b010);
        t = 0;
        while (job_beats < 10 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (job_beats < 10) check_eq("beat10_timeout", DW'(job_beats), DW'(10));
        @(posedge clk);
        #2;
        rst = 1'b1;
        req_valid = '0;
        exp_order.delete(); bq_addr.delete(); bq_beats.delete();
        burst_left = 0; cur_grant = -1; last_grant_m = N - 1; prev_wr_req = 1'b0; dones = 0;
        for (int i = 0; i < N; i++) begin
            src_cnt[i] = 0; exp_cnt[i] = 0; ack_flag[i] = 1'b0;
        end
`ifdef WBA_BRESP_WAIT_EN
        bpend = 0;
`endif
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_outputs", DW'({busy, wr_req, wr_valid, wr_data_last, req_ack, src_ready, job_done}), '0);

        job_addr[0] = 64'h2000; job_len[0] = 32'd64;
        job_addr[1] = 64'h5FC0; job_len[1] = 32'd130;
        job_addr[2] = 64'h8000; job_len[2] = 32'd1;
        run_round(3'b111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
